// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber micro-op command path.
// Used by the *_ctrl sequencers, kyber_cmd_arbiter and kyber_top.
//   - Opcode constants (OP_*) and field widths of one micro-op command.
//   - kyber_cmd_t: packed command bundle {op, slot_a, slot_b, param}.
//   - arb_state_e: arbiter FSM encoding.
package kyber_pkg;

  localparam int unsigned CMD_OP_W = 4;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned PARAM_W  = 4;
  localparam int unsigned CMD_W    = CMD_OP_W + 2 * SLOT_W + PARAM_W;

  localparam logic [CMD_OP_W-1:0] OP_NOP    = 4'd0;
  localparam logic [CMD_OP_W-1:0] OP_NTT    = 4'd1;
  localparam logic [CMD_OP_W-1:0] OP_INTT   = 4'd2;
  localparam logic [CMD_OP_W-1:0] OP_PWM    = 4'd3;
  localparam logic [CMD_OP_W-1:0] OP_ADD    = 4'd4;
  localparam logic [CMD_OP_W-1:0] OP_SUB    = 4'd5;
  localparam logic [CMD_OP_W-1:0] OP_CBD    = 4'd6;
  localparam logic [CMD_OP_W-1:0] OP_SAMPLE = 4'd7;
  localparam logic [CMD_OP_W-1:0] OP_COMPR  = 4'd8;
  localparam logic [CMD_OP_W-1:0] OP_DECOMP = 4'd9;
  localparam logic [CMD_OP_W-1:0] OP_ENCODE = 4'd10;
  localparam logic [CMD_OP_W-1:0] OP_DECODE = 4'd11;
  localparam logic [CMD_OP_W-1:0] OP_HASH   = 4'd12;
  localparam logic [CMD_OP_W-1:0] OP_COPY   = 4'd13;

  typedef struct packed {
    logic [CMD_OP_W-1:0] op;
    logic [SLOT_W-1:0]   slot_a;
    logic [SLOT_W-1:0]   slot_b;
    logic [PARAM_W-1:0]  param;
  } kyber_cmd_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/kyber_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index granted most recently; search starts just after it
//   gnt   : one-hot grant (0 when no request)
//   valid : any request present
module kyber_rr_pick #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IdxW = (N_REQ > 2) ? 2 : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  always_comb begin
    logic        found;
    int unsigned idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/kyber_cmd_arbiter.sv
// Shares the single kyber_top micro-op command port between N_REQ sequencers.
// One op is buffered per requester; the owner keeps the port for its whole
// sequence (while req_lock is high) because the slot bank is shared state.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_lock/req_cmd_start     per-requester sequence level / op valid pulse
//   req_cmd_op/slot_a/slot_b/param  packed per-requester op fields
//   req_cmd_done, req_gnt      completion pulse to owner, one-hot owner
//   m_cmd_*, m_cmd_start       registered op and start pulse to kyber_top
//   m_cmd_done                 completion pulse from kyber_top
//   err_overrun, err_timeout   error pulses
// Option: define KYBER_ARB_TIMEOUT_EN to enable the m_cmd_done watchdog.
module kyber_cmd_arbiter
  import kyber_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ-1:0]        req_cmd_start,
  input  logic [4*N_REQ-1:0]      req_cmd_op,
  input  logic [5*N_REQ-1:0]      req_cmd_slot_a,
  input  logic [5*N_REQ-1:0]      req_cmd_slot_b,
  input  logic [4*N_REQ-1:0]      req_cmd_param,
  output logic [N_REQ-1:0]        req_cmd_done,
  output logic [N_REQ-1:0]        req_gnt,
  output logic [CMD_OP_W-1:0]     m_cmd_op,
  output logic [SLOT_W-1:0]       m_cmd_slot_a,
  output logic [SLOT_W-1:0]       m_cmd_slot_b,
  output logic [PARAM_W-1:0]      m_cmd_param,
  output logic                    m_cmd_start,
  input  logic                    m_cmd_done,
  output logic                    err_overrun,
  output logic                    err_timeout
);

  localparam int unsigned IdxW = (N_REQ > 2) ? 2 : 1;

  arb_state_e       state_q, state_d;
  kyber_cmd_t       req_cmd [N_REQ];
  kyber_cmd_t       pend_q  [N_REQ];
  kyber_cmd_t       pend_d  [N_REQ];
  logic [N_REQ-1:0] pend_v_q, pend_v_d;
  logic [IdxW-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic             owner_v_q, owner_v_d;
  kyber_cmd_t       m_cmd_q, m_cmd_d;
  logic             m_start_q, m_start_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             overrun_q, overrun_d, timeout_q, timeout_d;
  logic [N_REQ-1:0] overrun_hit, cap_ok, pick_gnt;
  logic             pick_valid, timeout_hit, owner_ready;

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_cmd[i].op     = req_cmd_op[4*i +: 4];
      req_cmd[i].slot_a = req_cmd_slot_a[5*i +: 5];
      req_cmd[i].slot_b = req_cmd_slot_b[5*i +: 5];
      req_cmd[i].param  = req_cmd_param[4*i +: 4];
    end
  end

  // A start is dropped if that requester already has an op buffered or in flight.
  always_comb begin
    overrun_hit = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      overrun_hit[i] = req_cmd_start[i] &
                       (pend_v_q[i] | (owner_v_q && (owner_q == i[IdxW-1:0]) &&
                                       (state_q == StWait)));
    end
  end
  assign cap_ok = req_cmd_start & ~overrun_hit;

  kyber_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (pend_v_q),
    .last  (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_gnt[i]) pick_idx = i[IdxW-1:0];
    end
  end

  // Owner's op arriving this cycle counts too, so HOLD issues one cycle sooner.
  assign owner_ready = pend_v_q[owner_q] | cap_ok[owner_q];

`ifdef KYBER_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == StIssue)     wd_cnt_d = '0;
    else if (state_q == StWait) wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end

  // A real completion in the same cycle wins over the watchdog.
  assign timeout_hit = (state_q == StWait) && !m_cmd_done &&
                       (wd_cnt_q == 16'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (m_cmd_done)       state_d = StHold;
        else if (timeout_hit) state_d = StIdle;
      end
      StHold: begin
        if (owner_ready)            state_d = StIssue;
        else if (!req_lock[owner_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pend_v_d  = pend_v_q | cap_ok;
    owner_d   = owner_q;
    owner_v_d = owner_v_q;
    rr_ptr_d  = rr_ptr_q;
    m_cmd_d   = m_cmd_q;
    m_start_d = 1'b0;
    done_d    = '0;
    overrun_d = |overrun_hit;
    timeout_d = timeout_hit;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pend_d[i] = cap_ok[i] ? req_cmd[i] : pend_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d   = pick_idx;
          owner_v_d = 1'b1;
          rr_ptr_d  = pick_idx;
        end
      end
      StIssue: begin
        m_cmd_d            = pend_q[owner_q];
        m_start_d          = 1'b1;
        pend_v_d[owner_q]  = 1'b0;
      end
      StWait: begin
        if (m_cmd_done) begin
          done_d[owner_q] = 1'b1;
        end else if (timeout_hit) begin
          done_d[owner_q]   = 1'b1;
          owner_v_d         = 1'b0;
          pend_v_d[owner_q] = 1'b0;
        end
      end
      StHold: begin
        if (!owner_ready && !req_lock[owner_q]) owner_v_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q  <= '0;
      owner_q   <= '0;
      owner_v_q <= 1'b0;
      rr_ptr_q  <= IdxW'(N_REQ - 1);
      m_cmd_q   <= '0;
      m_start_q <= 1'b0;
      done_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) pend_q[i] <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      owner_q   <= owner_d;
      owner_v_q <= owner_v_d;
      rr_ptr_q  <= rr_ptr_d;
      m_cmd_q   <= m_cmd_d;
      m_start_q <= m_start_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < int'(N_REQ); i++) pend_q[i] <= pend_d[i];
    end
  end

  always_comb begin
    req_gnt = '0;
    if (owner_v_q) req_gnt[owner_q] = 1'b1;
  end

  assign m_cmd_op     = m_cmd_q.op;
  assign m_cmd_slot_a = m_cmd_q.slot_a;
  assign m_cmd_slot_b = m_cmd_q.slot_b;
  assign m_cmd_param  = m_cmd_q.param;
  assign m_cmd_start  = m_start_q;
  assign req_cmd_done = done_q;
  assign err_overrun  = overrun_q;
  assign err_timeout  = timeout_q;

endmodule

// File: tb/tb_kyber_cmd_arbiter.sv
// Directed testbench for kyber_cmd_arbiter (N_REQ=3, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// The watchdog scenario runs only when KYBER_ARB_TIMEOUT_EN is defined.
module tb_kyber_cmd_arbiter;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_lock, req_cmd_start, req_cmd_done, req_gnt;
  logic [4*N-1:0] req_cmd_op, req_cmd_param;
  logic [5*N-1:0] req_cmd_slot_a, req_cmd_slot_b;
  logic [3:0]   m_cmd_op, m_cmd_param;
  logic [4:0]   m_cmd_slot_a, m_cmd_slot_b;
  logic         m_cmd_start, m_cmd_done, err_overrun, err_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hits;
  bit seen;

  always #5 clk = ~clk;

  kyber_cmd_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_lock       (req_lock),
    .req_cmd_start  (req_cmd_start),
    .req_cmd_op     (req_cmd_op),
    .req_cmd_slot_a (req_cmd_slot_a),
    .req_cmd_slot_b (req_cmd_slot_b),
    .req_cmd_param  (req_cmd_param),
    .req_cmd_done   (req_cmd_done),
    .req_gnt        (req_gnt),
    .m_cmd_op       (m_cmd_op),
    .m_cmd_slot_a   (m_cmd_slot_a),
    .m_cmd_slot_b   (m_cmd_slot_b),
    .m_cmd_param    (m_cmd_param),
    .m_cmd_start    (m_cmd_start),
    .m_cmd_done     (m_cmd_done),
    .err_overrun    (err_overrun),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [3:0] op, input logic [4:0] sa,
                         input logic [4:0] sb, input logic [3:0] pr);
    req_cmd_op[4*i +: 4]     = op;
    req_cmd_slot_a[5*i +: 5] = sa;
    req_cmd_slot_b[5*i +: 5] = sb;
    req_cmd_param[4*i +: 4]  = pr;
  endtask

  task automatic start(input logic [N-1:0] mask);
    req_cmd_start = mask;
    tick();
    req_cmd_start = '0;
  endtask

  task automatic done_pulse();
    m_cmd_done = 1'b1;
    tick();
    m_cmd_done = 1'b0;
  endtask

  task automatic wait_mstart(input int max_cyc, output bit found);
    found = 1'b0;
    for (int k = 0; k < max_cyc && !found; k++) begin
      tick();
      if (m_cmd_start) found = 1'b1;
    end
  endtask

  task automatic count_mstart(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (m_cmd_start) cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    req_lock       = '0;
    req_cmd_start  = '0;
    req_cmd_op     = '0;
    req_cmd_slot_a = '0;
    req_cmd_slot_b = '0;
    req_cmd_param  = '0;
    m_cmd_done     = 1'b0;
    #1;
    check("rst_gnt", req_gnt, 0);
    check("rst_mstart", m_cmd_start, 0);
    check("rst_op", m_cmd_op, 0);
    check("rst_done", req_cmd_done, 0);
    check("rst_ovr", err_overrun, 0);
    check("rst_tmo", err_timeout, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: requester 0 runs three ops under lock
    req_lock = 3'b001;
    set_cmd(0, 4'd1, 5'd2, 5'd3, 4'd4);
    start(3'b001);
    tick();
    check("t1_gnt_issue", req_gnt, 3'b001);
    check("t1_no_start_yet", m_cmd_start, 0);
    tick();
    check("t1_mstart_3cyc", m_cmd_start, 1);
    check("t1_op", m_cmd_op, 4'd1);
    check("t1_sa", m_cmd_slot_a, 5'd2);
    check("t1_sb", m_cmd_slot_b, 5'd3);
    check("t1_pr", m_cmd_param, 4'd4);
    tick();
    check("t1_mstart_1cyc", m_cmd_start, 0);
    done_pulse();
    check("t1_done0", req_cmd_done, 3'b001);
    set_cmd(0, 4'd2, 5'd5, 5'd6, 4'd7);
    start(3'b001);
    check("t1_done_pulse", req_cmd_done, 0);
    tick();
    check("t1_mstart_2cyc", m_cmd_start, 1);
    check("t1_op2", m_cmd_op, 4'd2);
    check("t1_gnt2", req_gnt, 3'b001);
    done_pulse();
    check("t1_done1", req_cmd_done, 3'b001);
    set_cmd(0, 4'd3, 5'd8, 5'd9, 4'd10);
    start(3'b001);
    tick();
    check("t1_op3", m_cmd_op, 4'd3);
    done_pulse();
    check("t1_done2", req_cmd_done, 3'b001);
    check("t1_gnt3", req_gnt, 3'b001);
    req_lock = 3'b000;
    tick();
    check("t1_release", req_gnt, 0);

    // 2: simultaneous starts from reset, req0 first
    do_reset();
    req_lock = 3'b011;
    set_cmd(0, 4'd3, 5'd1, 5'd1, 4'd1);
    set_cmd(1, 4'd7, 5'd2, 5'd2, 4'd2);
    start(3'b011);
    tick();
    check("t2_gnt_r0", req_gnt, 3'b001);
    tick();
    check("t2_op_r0", m_cmd_op, 4'd3);
    done_pulse();
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (m_cmd_start || req_gnt != 3'b001) hits++;
    end
    check("t2_r1_waits", hits, 0);
    req_lock = 3'b010;
    tick();
    check("t2_released", req_gnt, 0);
    tick();
    check("t2_gnt_r1", req_gnt, 3'b010);
    tick();
    check("t2_mstart_r1", m_cmd_start, 1);
    check("t2_op_r1", m_cmd_op, 4'd7);
    done_pulse();
    check("t2_done_r1", req_cmd_done, 3'b010);
    req_lock = 3'b000;
    tick();
    tick();

    // 3: req1 starts while req0 holds the port
    req_lock = 3'b001;
    set_cmd(0, 4'd5, 5'd0, 5'd0, 4'd0);
    start(3'b001);
    wait_mstart(5, seen);
    check("t3_r0_mstart", seen, 1);
    done_pulse();
    set_cmd(1, 4'd12, 5'd13, 5'd7, 4'd9);
    start(3'b010);
    count_mstart(5, hits);
    check("t3_no_issue_r1", hits, 0);
    check("t3_gnt_hold", req_gnt, 3'b001);
    req_lock = 3'b000;
    wait_mstart(10, seen);
    check("t3_r1_mstart", seen, 1);
    check("t3_gnt_r1", req_gnt, 3'b010);
    check("t3_op", m_cmd_op, 4'd12);
    check("t3_sa", m_cmd_slot_a, 5'd13);
    check("t3_sb", m_cmd_slot_b, 5'd7);
    check("t3_pr", m_cmd_param, 4'd9);
    done_pulse();
    check("t3_done_r1", req_cmd_done, 3'b010);
    tick();
    check("t3_unlocked_release", req_gnt, 0);

    // 4: second start during WAIT is an overrun and is dropped
    req_lock = 3'b001;
    set_cmd(0, 4'd5, 5'd1, 5'd2, 4'd3);
    start(3'b001);
    wait_mstart(5, seen);
    check("t4_mstart", seen, 1);
    set_cmd(0, 4'd6, 5'd4, 5'd4, 4'd4);
    start(3'b001);
    check("t4_overrun", err_overrun, 1);
    tick();
    check("t4_overrun_pulse", err_overrun, 0);
    done_pulse();
    check("t4_done", req_cmd_done, 3'b001);
    count_mstart(5, hits);
    check("t4_dropped", hits, 0);
    check("t4_op_held", m_cmd_op, 4'd5);
    req_lock = 3'b000;
    tick();
    check("t4_release", req_gnt, 0);

    // 5: reset during WAIT abandons the op
    req_lock = 3'b001;
    start(3'b001);
    wait_mstart(5, seen);
    check("t5_mstart", seen, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", req_gnt, 0);
    check("t5_rst_mstart", m_cmd_start, 0);
    check("t5_rst_op", m_cmd_op, 0);
    tick();
    rst_n = 1'b1;
    done_pulse();
    check("t5_late_done", req_cmd_done, 0);
    check("t5_gnt_idle", req_gnt, 0);
    req_lock = 3'b000;
    tick();

`ifdef KYBER_ARB_TIMEOUT_EN
    // 6: watchdog releases the port and the next requester is granted
    req_lock = 3'b011;
    set_cmd(0, 4'd1, 5'd1, 5'd1, 4'd1);
    set_cmd(1, 4'd9, 5'd3, 5'd3, 4'd3);
    start(3'b011);
    wait_mstart(5, seen);
    check("t6_r0_mstart", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (err_timeout) seen = 1'b1;
    end
    check("t6_timeout", seen, 1);
    check("t6_done_r0", req_cmd_done, 3'b001);
    check("t6_gnt_none", req_gnt, 0);
    wait_mstart(10, seen);
    check("t6_r1_mstart", seen, 1);
    check("t6_gnt_r1", req_gnt, 3'b010);
    check("t6_op_r1", m_cmd_op, 4'd9);
    done_pulse();
    check("t6_done_r1", req_cmd_done, 3'b010);
    req_lock = 3'b000;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
